// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data and full/empty flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module sync_fifo #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 8,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  ,
  output logic                  overflow,
  output logic                  underflow
`endif
);

  localparam int CNT_WIDTH = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0]  count;
  logic                  rd_accept;
  logic                  wr_accept;

  // A write into a full FIFO is only allowed when a read frees the slot on the same edge.
  always_comb begin
    rd_accept = rd_en && !empty;
    wr_accept = wr_en && (!full || rd_accept);
  end

  always_comb begin
    full  = (count == CNT_WIDTH'(DEPTH));
    empty = (count == '0);
  end

  // Storage is left uninitialised on reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (!reset && wr_accept) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      data_out <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (rd_accept) begin
        rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
        data_out <= mem[rd_ptr];
      end
      if (wr_accept && !rd_accept) begin
        count <= count + CNT_WIDTH'(1);
      end else if (rd_accept && !wr_accept) begin
        count <= count - CNT_WIDTH'(1);
      end
    end
  end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full && !rd_accept) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo: a queue model predicts read data and flags.
// Build with SYNC_FIFO_ERR_FLAGS_EN defined to also check overflow/underflow.
module tb_sync_fifo;

  localparam int DW    = 4;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_en;
  logic          wr_en;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          full;
  logic          empty;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic          overflow;
  logic          underflow;
`endif

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sb [$];
  logic [DW-1:0] exp_dout;
  logic          exp_ovf;
  logic          exp_udf;

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  always #5 clk = ~clk;

  // One clock of stimulus; the model decides acceptance from its own state.
  task automatic tick(input logic r, input logic w, input logic [DW-1:0] d);
    bit rd_ok;
    bit wr_ok;
    rd_en   = r;
    wr_en   = w;
    data_in = d;
    rd_ok = r && (sb.size() != 0);
    wr_ok = w && ((sb.size() != DEPTH) || rd_ok);
    if (w && sb.size() == DEPTH && !rd_ok) exp_ovf = 1'b1;
    if (r && sb.size() == 0) exp_udf = 1'b1;
    @(posedge clk);
    if (rd_ok) exp_dout = sb.pop_front();
    if (wr_ok) sb.push_back(d);
    #1;
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic do_reset(input int unsigned n);
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    sb.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++;
    if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
    checks++;
    if (data_out !== 4'd0) begin errors++; $display("FAIL reset_dout: got %0d expected 0", data_out); end
    tick(1'b1, 1'b0, 4'd0);
    checks++;
    if (data_out !== 4'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL empty_read: got dout=%0d empty=%b expected 0/1", data_out, empty);
    end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    checks++;
    if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b expected 1", underflow); end
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear: got %b expected 0", overflow); end
`endif
  endtask

  task automatic test_fill();
    do_reset(1);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      tick(1'b0, 1'b1, DW'(i));
      checks++;
      if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d]: got %b expected 0", i, empty); end
      checks++;
      if (full !== (i == DEPTH - 1)) begin
        errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, (i == DEPTH - 1));
      end
    end
    for (int unsigned v = 8; v <= 10; v++) begin
      tick(1'b0, 1'b1, DW'(v));
      checks++;
      if (full !== 1'b1) begin errors++; $display("FAIL drop_full[%0d]: got %b expected 1", v, full); end
    end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b expected 1", overflow); end
`endif
  endtask

  task automatic test_drain();
    for (int unsigned i = 0; i < DEPTH; i++) begin
      tick(1'b1, 1'b0, 4'd0);
      checks++;
      if (data_out !== DW'(i) || data_out !== exp_dout) begin
        errors++; $display("FAIL drain_data[%0d]: got %0d expected %0d", i, data_out, i);
      end
      checks++;
      if (empty !== (i == DEPTH - 1) || full !== 1'b0) begin
        errors++; $display("FAIL drain_flags[%0d]: got empty=%b full=%b", i, empty, full);
      end
    end
    tick(1'b0, 1'b0, 4'd0);
    tick(1'b1, 1'b0, 4'd0);
    checks++;
    if (data_out !== 4'd7) begin errors++; $display("FAIL drain_hold: got %0d expected 7", data_out); end
  endtask

  task automatic test_simul_full();
    do_reset(1);
    for (int unsigned i = 0; i < DEPTH; i++) tick(1'b0, 1'b1, DW'(i));
    tick(1'b1, 1'b1, 4'd13);
    checks++;
    if (data_out !== 4'd0 || full !== 1'b1) begin
      errors++; $display("FAIL simul_full: got dout=%0d full=%b expected 0/1", data_out, full);
    end
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      tick(1'b1, 1'b0, 4'd0);
      checks++;
      if (data_out !== ((k == DEPTH) ? 4'd13 : DW'(k))) begin
        errors++; $display("FAIL simul_full_read[%0d]: got %0d expected %0d", k, data_out,
                           (k == DEPTH) ? 13 : k);
      end
    end
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL simul_full_empty: got %b expected 1", empty); end
  endtask

  task automatic test_simul_empty();
    do_reset(1);
    tick(1'b1, 1'b1, 4'd6);
    checks++;
    if (empty !== 1'b0 || data_out !== 4'd0) begin
      errors++; $display("FAIL simul_empty: got empty=%b dout=%0d expected 0/0", empty, data_out);
    end
    tick(1'b0, 1'b1, 4'd2);
    tick(1'b1, 1'b1, 4'd3);
    checks++;
    if (data_out !== 4'd6 || empty !== 1'b0) begin
      errors++; $display("FAIL simul_mid: got dout=%0d empty=%b expected 6/0", data_out, empty);
    end
  endtask

  task automatic test_wrap();
    do_reset(1);
    for (int unsigned i = 1; i <= 5; i++) tick(1'b0, 1'b1, DW'(i));
    for (int unsigned i = 1; i <= 5; i++) tick(1'b1, 1'b0, 4'd0);
    for (int unsigned i = 11; i <= 15; i++) tick(1'b0, 1'b1, DW'(i));
    for (int unsigned i = 11; i <= 15; i++) begin
      tick(1'b1, 1'b0, 4'd0);
      checks++;
      if (data_out !== DW'(i)) begin errors++; $display("FAIL wrap_data: got %0d expected %0d", data_out, i); end
    end
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", empty); end
  endtask

  task automatic test_reset_mid();
    do_reset(1);
    tick(1'b0, 1'b1, 4'd3);
    tick(1'b0, 1'b1, 4'd4);
    tick(1'b0, 1'b1, 4'd5);
    tick(1'b1, 1'b1, 4'd9);
    rd_en = 1'b1;
    wr_en = 1'b1;
    data_in = 4'd1;
    do_reset(1);
    rd_en = 1'b0;
    wr_en = 1'b0;
    checks++;
    if (empty !== 1'b1 || full !== 1'b0 || data_out !== 4'd0) begin
      errors++; $display("FAIL reset_mid: got empty=%b full=%b dout=%0d expected 1/0/0", empty, full, data_out);
    end
    tick(1'b0, 1'b1, 4'd10);
    tick(1'b1, 1'b0, 4'd0);
    checks++;
    if (data_out !== 4'd10 || empty !== 1'b1) begin
      errors++; $display("FAIL reset_mid_data: got dout=%0d empty=%b expected 10/1", data_out, empty);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(1);
    for (int unsigned n = 0; n < 300; n++) begin
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), DW'($urandom));
      checks++;
      if (data_out !== exp_dout) begin
        errors++; $display("FAIL random_data[%0d]: got %0d expected %0d", n, data_out, exp_dout);
      end
      checks++;
      if (full !== (sb.size() == DEPTH) || empty !== (sb.size() == 0)) begin
        errors++; $display("FAIL random_flags[%0d]: got full=%b empty=%b expected occupancy %0d",
                           n, full, empty, sb.size());
      end
    end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    checks++;
    if (overflow !== exp_ovf || underflow !== exp_udf) begin
      errors++; $display("FAIL random_err_flags: got ovf=%b udf=%b expected %b/%b",
                         overflow, underflow, exp_ovf, exp_udf);
    end
`endif
  endtask

  initial begin
    reset    = 1'b1;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    data_in  = '0;
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
    test_reset();
    test_fill();
    test_drain();
    test_simul_full();
    test_simul_empty();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
Single-clock first-in/first-out buffer for small data words, 4 bits by default. Sits between a producer and a consumer in the same clock domain and decouples their rates. Provides full and empty status flags. Read data is registered: it appears one clock after the read is accepted.

Parameters:
DATA_WIDTH, 4, width of data_in and data_out in bits.
DEPTH, 8, number of storage entries; must be a power of 2 and at least 2.
ADDR_WIDTH, log2(DEPTH) = 3, pointer width; derived from DEPTH, not overridden independently.

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
rd_en  input  1  read request.
wr_en  input  1  write request.
data_in  input  DATA_WIDTH  write data, sampled on a clock edge with an accepted write.
data_out  output  DATA_WIDTH  registered read data.
full  output  1  high when DEPTH entries are stored.
empty  output  1  high when 0 entries are stored.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset takes priority over everything else. On a rising edge with reset=1:
  - write pointer, read pointer and occupancy count go to 0;
  - data_out goes to 0, empty=1, full=0;
  - memory contents are don't-care and are not cleared.
- Reset asserted mid-operation discards all stored data at that edge. rd_en and wr_en are ignored on that edge.
- Accepted write: wr_en=1 and (full=0, or rd_en=1 with a read accepted on the same edge).
  - data_in is stored at mem[wr_ptr], and wr_ptr increments modulo DEPTH.
- Accepted read: rd_en=1 and empty=0.
  - data_out <= mem[rd_ptr], and rd_ptr increments modulo DEPTH.
  - Read latency is 1 clock: the word is visible on data_out right after the accepting edge.
- No accepted read: data_out holds its previous value.
- Write when full without a simultaneous read: the write is dropped silently, with no state change.
- Read when empty: ignored. data_out holds, and pointers are unchanged.
- Simultaneous rd_en and wr_en:
  - not empty, not full: both are performed and the count is unchanged.
  - full: both are performed; the oldest word is read and the new word is stored in the freed slot, so full stays 1.
  - empty: only the write is performed; empty becomes 0 after the edge, and data_out holds.
- Occupancy count ranges 0..DEPTH, width ADDR_WIDTH+1:
  - increments on write-only;
  - decrements on read-only;
  - unchanged on both or neither.
- full = (count == DEPTH) and empty = (count == 0). Both flags reflect the post-edge state, with no added latency.
- full and empty are never high together.
- Pointers wrap from DEPTH-1 to 0. Ordering is strictly FIFO across wrap-around.

Optional Feature:
Macro SYNC_FIFO_ERR_FLAGS_EN.
- Defined: adds two 1-bit outputs, overflow and underflow.
  - overflow is set on an edge where a write is dropped (wr_en=1, full=1, no accepted read).
  - underflow is set on an edge where rd_en=1 and empty=1.
  - Both are sticky until reset and reset to 0.
  - Core FIFO behaviour is unchanged.
- Not defined: these ports and their logic do not exist, and the port list is exactly as above.

Test Plan:
- Reset: hold reset=1 for 2 clocks -> empty=1, full=0, data_out=0; then rd_en=1 on an empty FIFO -> data_out stays 0, empty stays 1 (underflow=1 if the macro is defined).
- Fill: after reset, write 0..7 on consecutive edges -> empty=0 after the first edge and full=1 after the 8th edge. Then write 8, 9, 10 -> dropped, full stays 1.
- Drain: from the full state, rd_en=1 for 8 clocks -> data_out = 0,1,...,7 each one clock after the accepting edge. empty=1 after the 8th read, and data_out holds 7 afterwards.
- Simultaneous when full: full with 0..7, rd_en=wr_en=1 with data_in=13 -> data_out=0, full stays 1. Continued reads return 1..7 then 13.
- Wrap-around: write 5 words, read 5, then write 11, 12, 13, 14, 15 and read all -> data_out = 11, 12, 13, 14, 15 in order, and empty=1 at the end.
- Reset mid-operation: with 3 stored words, assert reset for 1 edge -> empty=1, full=0, data_out=0. A subsequent write of 10 followed by a read returns 10.
